muldiv_seq: RTL
===============

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width; only 32 is required to be supported.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to launch an operation, sampled at the clk edge.
REQ-005 The block SHALL have port opcode, input, 4 bits: 4'ha MUL, 4'hb DIV, 4'hc MULU, 4'hd DIVU.
REQ-006 The block SHALL have port data0, input, 32 bits: multiplicand or dividend.
REQ-007 The block SHALL have port data1, input, 32 bits: multiplier or divisor.
REQ-008 The block SHALL have port busy, output, 1 bit: an operation is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: single-cycle completion pulse.
REQ-010 The block SHALL have port out_hi, output, 32 bits: product[63:32] for MUL/MULU, remainder for DIV/DIVU.
REQ-011 The block SHALL have port out_lo, output, 32 bits: product[31:0] for MUL/MULU, quotient for DIV/DIVU.
REQ-012 The block SHALL have port div_by_zero, output, 1 bit: the last completed divide had data1 == 0.

Function
REQ-013 The block SHALL implement FSM states IDLE, RUN and FIX.
REQ-014 The FSM SHALL move IDLE->RUN when start is high and opcode is valid, except that it SHALL move IDLE->FIX when start is high, the op is DIV/DIVU and data1 == 0.
REQ-015 RUN SHALL last exactly 32 cycles, with a 5-bit iteration counter counting 0..31, then go to FIX.
REQ-016 FIX SHALL apply the sign correction, write out_hi, out_lo and div_by_zero, pulse done, and return to IDLE.
REQ-017 Operands and opcode SHALL be latched when start is accepted; later changes on the inputs SHALL have no effect on the running operation.
REQ-018 If start is accepted at edge E0, busy SHALL be high from E0 to E33, and done plus the results SHALL be updated at E33, a latency of 33 cycles.
REQ-019 For a divide by zero the latency SHALL be 1 cycle: done at E1.
REQ-020 start SHALL be ignored while busy is high.
REQ-021 start with an opcode outside 4'ha..4'hd SHALL be ignored: no busy, no done, no output change.
REQ-022 start SHALL be accepted in the same cycle that done is high, since the FSM is in IDLE then.
REQ-023 done SHALL be high for exactly one cycle per accepted operation.
REQ-024 out_hi, out_lo and div_by_zero SHALL hold their value until the next completion.
REQ-025 MULU SHALL use iterative shift-add, one multiplier bit per cycle, into a 64-bit accumulator.
REQ-026 MUL SHALL multiply the magnitudes and negate the 64-bit result when the operand signs differ.
REQ-027 DIVU SHALL use restoring division, one quotient bit per cycle, with a 33-bit partial remainder.
REQ-028 DIV SHALL divide the magnitudes; the quotient SHALL be negated when the signs differ, and the remainder SHALL take the sign of the dividend (truncating division).
REQ-029 DIV of 0x80000000 by 0xFFFFFFFF SHALL give quotient 0x80000000 and remainder 0, with no flag.
REQ-030 A divide by zero SHALL give out_lo = 0xFFFFFFFF, out_hi = data0 and div_by_zero = 1.
REQ-031 A completed MUL or MULU SHALL clear div_by_zero.

Reset
REQ-032 While rst is high, the state SHALL be IDLE and busy, done, out_hi, out_lo, div_by_zero and the counter SHALL be 0, asynchronously.
REQ-033 A reset asserted mid-operation SHALL abort the operation with no done pulse; the first start after rst falls SHALL be accepted normally.

Structure
REQ-034 Shared package alu_pkg SHALL hold the opcode constants OP_MUL/OP_DIV/OP_MULU/OP_DIVU (4'ha..4'hd), the state enum and WIDTH, shared with the ALU and the decoder.
REQ-035 One sub-module SHALL exist: muldiv_step, combinational, performing one add-shift or one subtract-restore iteration; all sequencing SHALL stay in muldiv_seq.

Verification
REQ-036 MULU 0xFFFFFFFF*0xFFFFFFFF SHALL give out_hi 0xFFFFFFFE and out_lo 0x00000001, with done exactly 33 cycles after start and busy high for 33 cycles.
REQ-037 MUL 0xFFFFFFFD*0x00000007 SHALL give out_hi 0xFFFFFFFF and out_lo 0xFFFFFFEB, and DIVU 100/7 SHALL give out_lo 14 and out_hi 2.
REQ-038 DIV 0xFFFFFFF9/2 SHALL give out_lo 0xFFFFFFFD and out_hi 0xFFFFFFFF, and DIV 0x80000000/0xFFFFFFFF SHALL give out_lo 0x80000000 and out_hi 0.
REQ-039 DIVU 0x12345678/0 SHALL give done at cycle 1, out_lo 0xFFFFFFFF, out_hi 0x12345678 and div_by_zero 1; a following MULU 2*3 SHALL give 6 and div_by_zero 0.
REQ-040 A second start with changed operands at cycle 5 of RUN SHALL be ignored with the result unchanged, and a back-to-back start in the done cycle SHALL be accepted.
REQ-041 rst pulsed at cycle 10 of RUN SHALL force all outputs to 0 with no done pulse, and a fresh MULU 3*4 afterwards SHALL give out_lo 12.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand width, multiply/divide opcodes, sequencer state
// encoding and small opcode decode helpers.
package alu_pkg;

  localparam int WIDTH = 32;

  localparam logic [3:0] OP_MUL  = 4'ha;
  localparam logic [3:0] OP_DIV  = 4'hb;
  localparam logic [3:0] OP_MULU = 4'hc;
  localparam logic [3:0] OP_DIVU = 4'hd;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  function automatic logic op_valid(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MULU) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_div(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the sequential multiplier/divider: a shift-add step on {hi,lo}
// for multiply, or a restoring subtract step producing one quotient bit for divide.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             div_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_shift;
  logic           ge;

  always_comb begin
    sum       = {1'b0, hi_i} + {1'b0, (lo_i[0] ? b_i : {WIDTH{1'b0}})};
    // 33-bit partial remainder: previous remainder shifted left with the next dividend bit
    rem_shift = {hi_i, lo_i[WIDTH-1]};
    ge        = (rem_shift >= {1'b0, b_i});
    hi_o      = sum[WIDTH:1];
    lo_o      = {sum[0], lo_i[WIDTH-1:1]};
    if (div_i) begin
      hi_o = ge ? WIDTH'(rem_shift - {1'b0, b_i}) : rem_shift[WIDTH-1:0];
      lo_o = {lo_i[WIDTH-2:0], ge};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential 32x32 multiply / 32/32 divide, signed and unsigned; 33-cycle latency
// (1 cycle for divide by zero), start ignored while busy or with an unknown opcode.
module muldiv_seq #(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out_hi,
  output logic [WIDTH-1:0] out_lo,
  output logic             div_by_zero
);

  import alu_pkg::*;

  state_t           state_q;
  logic [4:0]       cnt_q;
  logic             div_q;
  logic             neg_lo_q;
  logic             neg_hi_q;
  logic             dbz_q;
  logic [WIDTH-1:0] hi_q, lo_q, b_q;
  logic [WIDTH-1:0] hi_d, lo_d;
  logic             busy_q, done_q, dbz_out_q;
  logic [WIDTH-1:0] out_hi_q, out_lo_q;

  logic             in_div, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [2*WIDTH-1:0] prod_fix;

  assign in_div   = op_is_div(opcode);
  assign a_neg    = op_is_signed(opcode) & data0[WIDTH-1];
  assign b_neg    = op_is_signed(opcode) & data1[WIDTH-1];
  assign a_mag    = a_neg ? -data0 : data0;
  assign b_mag    = b_neg ? -data1 : data1;
  assign prod_fix = neg_lo_q ? -{hi_q, lo_q} : {hi_q, lo_q};

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div_i (div_q),
    .hi_i  (hi_q),
    .lo_i  (lo_q),
    .b_i   (b_q),
    .hi_o  (hi_d),
    .lo_o  (lo_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_q     <= 1'b0;
      neg_lo_q  <= 1'b0;
      neg_hi_q  <= 1'b0;
      dbz_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      b_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      out_hi_q  <= '0;
      out_lo_q  <= '0;
      dbz_out_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && op_valid(opcode)) begin
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            div_q    <= in_div;
            neg_lo_q <= a_neg ^ b_neg;
            neg_hi_q <= a_neg;
            hi_q     <= '0;
            // multiply keeps the multiplier in lo so its bits shift out as the product shifts in
            lo_q     <= in_div ? a_mag : b_mag;
            b_q      <= in_div ? b_mag : a_mag;
            if (in_div && (data1 == '0)) begin
              dbz_q   <= 1'b1;
              hi_q    <= data0;
              state_q <= FIX;
            end else begin
              dbz_q   <= 1'b0;
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_q <= FIX;
        end
        FIX: begin
          if (dbz_q) begin
            out_hi_q  <= hi_q;
            out_lo_q  <= '1;
            dbz_out_q <= 1'b1;
          end else if (div_q) begin
            out_hi_q  <= neg_hi_q ? -hi_q : hi_q;
            out_lo_q  <= neg_lo_q ? -lo_q : lo_q;
            dbz_out_q <= 1'b0;
          end else begin
            out_hi_q  <= prod_fix[2*WIDTH-1:WIDTH];
            out_lo_q  <= prod_fix[WIDTH-1:0];
            dbz_out_q <= 1'b0;
          end
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign out_hi      = out_hi_q;
  assign out_lo      = out_lo_q;
  assign div_by_zero = dbz_out_q;

endmodule
